moore_fsm_ov: RTL and testbench
===============================

Name: moore_fsm_ov

Overview:
Moore-type finite state machine that detects the serial bit pattern "101" on a 1-bit input stream, with overlapping detection allowed. The output is a decode of the current state only, so it asserts for exactly one full clock cycle after the clock edge that samples the final '1' of the pattern. It is a standalone leaf block used as a serial pattern detector, clocked by a single system clock.

Parameters:
none (state encoding is internal; a 2-bit binary encoding is required: S0=00, S1=01, S2=10, S3=11)

Ports:
clk  input  1  system clock; all state updates occur on the rising edge
rst  input  1  asynchronous, active-high reset; forces state S0 immediately
in   input  1  serial data bit, sampled on each rising edge of clk
out  input/output note: out is an output  1  detection flag; high only while in state S3
Port declaration order is in, rst, clk, out. Instances connect positionally in that order.

Behaviour:
- Single clock domain: rising edge of clk. Reset is asynchronous and active-high (rst), as already decided.
- While rst=1, state=S0 and out=0, regardless of clk or in.
  - Reset takes effect immediately, not at the next edge.
  - Reset asserted mid-pattern discards all partial-match history.
- After rst deasserts, the first rising edge evaluates transitions from S0.
- States (meaning = longest suffix of the input history that is a prefix of "101"):
  - S0: no match. out=0.
  - S1: seen "1". out=0.
  - S2: seen "10". out=0.
  - S3: seen "101". out=1.
- Transitions, evaluated on each rising clk edge using the sampled in:
  - S0: in=1 -> S1; in=0 -> S0.
  - S1: in=1 -> S1; in=0 -> S2.
  - S2: in=1 -> S3; in=0 -> S0.
  - S3: in=1 -> S1; in=0 -> S2. This is the overlap rule: the trailing '1' of a detected "101" starts the next match.
- Output is a pure function of state (Moore): out = (state == S3).
  - No combinational path from in to out.
  - out changes only on a clk rising edge or on rst assertion.
- Latency: out rises one clock after the edge that samples the final '1', i.e. it is visible during the cycle following that edge. It stays high for exactly one cycle unless the pattern completes again on the next edge, which cannot happen for "101".
- Back-to-back overlapping patterns ("10101") give two detections, spaced two cycles apart.
- Runs of 1s ("111") hold S1. "100" returns to S0.
- Illegal or unreachable encodings are not possible with 2 bits / 4 states. A default branch is still required that returns to S0 with out=0.
- No enable input: the FSM advances on every clock edge.

Test Plan:
- Reset: rst=1 for 1.5 cycles with in=0 -> out=0 throughout; state S0. Release rst, hold in=0 for 2 cycles -> out stays 0.
- Basic detect: in sequence 0,1,0,1 (one bit per cycle) -> out=1 only in the cycle after the edge sampling the 4th bit. out=0 before that.
- Non-match break: continue with 0,0 -> out returns to 0 and stays 0 (S3->S2->S0).
- Overlap: continue with 1,0,1,0,1 -> out pulses after the 3rd bit (first "101"), then again after the 5th bit. The second pulse reuses the shared '1'. Two pulses, two cycles apart.
  - Full stream after reset: 0,1,0,1,0,0,1,0,1,0,1 -> exactly three one-cycle out pulses, following bits 4, 9 and 11.
- Runs and async reset: in=1,1,1,0,1 -> single pulse after the final bit. Separately, assert rst asynchronously while in S3 -> out drops to 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/moore_fsm_ov.sv
// Moore detector for the serial pattern "101" with overlapping matches.
// out is registered and decodes only the current state, so it never depends combinationally on in.
module moore_fsm_ov (
  input  logic in,
  input  logic rst,
  input  logic clk,
  output logic out
);

  // The state value is the longest suffix of the input history that is also a prefix of "101".
  typedef enum logic [1:0] {
    S0 = 2'b00,  // no match
    S1 = 2'b01,  // seen "1"
    S2 = 2'b10,  // seen "10"
    S3 = 2'b11   // seen "101"
  } state_t;

  state_t state;

  function automatic state_t next_state(input state_t cur, input logic bit_in);
    case (cur)
      S0:      return bit_in ? S1 : S0;
      S1:      return bit_in ? S1 : S2;
      S2:      return bit_in ? S3 : S0;
      // The trailing '1' of a completed match is the first '1' of the next match.
      S3:      return bit_in ? S1 : S2;
      default: return S0;
    endcase
  endfunction

  // NOTE: the reset is in the sensitivity list so it acts at once, without waiting for a clock
  // edge. State updates use <= so every register samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
      out   <= 1'b0;
    end else begin
      state <= next_state(state, in);
      // out is loaded together with its state, so it is high exactly while state is S3.
      out   <= (next_state(state, in) == S3);
    end
  end

endmodule

// File: tb/tb_moore_fsm_ov.sv
// Scoreboard bench for moore_fsm_ov: a 3-bit history model predicts out for every driven bit.
// Inputs change right after a falling edge and out is sampled on the next falling edge.
module tb_moore_fsm_ov;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic dout;

  int n_cmp = 0;
  int n_err = 0;

  logic       sb[$];
  logic [2:0] hist = 3'b000;

  moore_fsm_ov dut (
    .in (din),
    .rst(rst),
    .clk(clk),
    .out(dout)
  );

  always #5 clk = ~clk;

  // Drive one bit, queue the prediction, and return on the following falling edge.
  task automatic step(input logic b);
    din  = b;
    hist = {hist[1:0], b};
    sb.push_back(hist == 3'b101);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic model_reset();
    hist = 3'b000;
  endtask

  task automatic test_reset();
    logic exp;
    rst = 1'b1;
    din = 1'b0;
    model_reset();
    #3;
    n_cmp++;
    if (dout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_early: out=%b expected 0", dout);
    end
    #12;  // 1.5 cycles of reset in total, one rising edge already seen
    n_cmp++;
    if (dout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_held: out=%b expected 0", dout);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0);
      exp = sb.pop_front();
      n_cmp++;
      if (dout !== exp) begin
        n_err++;
        $display("FAIL reset_idle[%0d]: out=%b expected %b", i, dout, exp);
      end
    end
  endtask

  // Full stream 0,1,0,1,0,0,1,0,1,0,1 split into basic, break and overlap parts.
  task automatic test_basic(output int pulses);
    logic [3:0] s = 4'b0101;
    logic exp;
    pulses = 0;
    for (int i = 3; i >= 0; i--) begin
      step(s[i]);
      exp = sb.pop_front();
      pulses += int'(dout === 1'b1);
      n_cmp++;
      if (dout !== exp) begin
        n_err++;
        $display("FAIL basic[%0d]: out=%b expected %b", 3 - i, dout, exp);
      end
    end
  endtask

  task automatic test_break(output int pulses);
    logic exp;
    pulses = 0;
    for (int i = 0; i < 2; i++) begin
      step(1'b0);
      exp = sb.pop_front();
      pulses += int'(dout === 1'b1);
      n_cmp++;
      if (dout !== exp) begin
        n_err++;
        $display("FAIL break[%0d]: out=%b expected %b", i, dout, exp);
      end
    end
  endtask

  task automatic test_overlap(output int pulses);
    logic [4:0] s = 5'b10101;
    logic exp;
    pulses = 0;
    for (int i = 4; i >= 0; i--) begin
      step(s[i]);
      exp = sb.pop_front();
      pulses += int'(dout === 1'b1);
      n_cmp++;
      if (dout !== exp) begin
        n_err++;
        $display("FAIL overlap[%0d]: out=%b expected %b", 4 - i, dout, exp);
      end
    end
  endtask

  task automatic test_stream();
    int p0, p1, p2;
    test_basic(p0);
    test_break(p1);
    test_overlap(p2);
    n_cmp++;
    if (p0 + p1 + p2 !== 3) begin
      n_err++;
      $display("FAIL stream_pulses: got %0d pulses expected 3", p0 + p1 + p2);
    end
  endtask

  // "111" holds in S1, then "0,1" completes one match; "100" must clear back to no-match.
  task automatic test_runs();
    logic [8:0] s = 9'b111011001;
    logic exp;
    for (int i = 8; i >= 0; i--) begin
      step(s[i]);
      exp = sb.pop_front();
      n_cmp++;
      if (dout !== exp) begin
        n_err++;
        $display("FAIL runs[%0d]: out=%b expected %b", 8 - i, dout, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] s = 3'b101;
    logic exp;
    for (int i = 2; i >= 0; i--) begin
      step(s[i]);
      exp = sb.pop_front();
      n_cmp++;
      if (dout !== exp) begin
        n_err++;
        $display("FAIL async_pre[%0d]: out=%b expected %b", 2 - i, dout, exp);
      end
    end
    // out is high here; the next rising edge is 5 time units away.
    rst = 1'b1;
    #1;
    n_cmp++;
    if (dout !== 1'b0) begin
      n_err++;
      $display("FAIL async_drop: out=%b expected 0", dout);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // "10" then reset then "1": the partial match must not survive reset.
  task automatic test_reset_midpattern();
    logic [1:0] s = 2'b10;
    logic exp;
    for (int i = 1; i >= 0; i--) begin
      step(s[i]);
      exp = sb.pop_front();
      n_cmp++;
      if (dout !== exp) begin
        n_err++;
        $display("FAIL mid_pre[%0d]: out=%b expected %b", 1 - i, dout, exp);
      end
    end
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(1'b1);
    exp = sb.pop_front();
    n_cmp++;
    if (dout !== exp) begin
      n_err++;
      $display("FAIL mid_post: out=%b expected %b", dout, exp);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_runs();
    test_async_reset();
    test_reset_midpattern();
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
